// File: rtl/read_bytes.sv
// -----------------------------------------------------------------------------
// read_bytes
//   Reads 1..4 consecutive bytes from a byte-wide RAM/flash buffer and packs
//   them into a 32-bit word. This is the read-side partner of the byte writer.
//   It uses the same buffer addressing, the same rd_clock strobe style and the
//   same start/done handshake. The upgrade controller uses it to fetch header
//   and CRC words.
//
//   Parameters
//     NUMBER      buffer depth in bytes (address width AW = clog2(NUMBER))
//     RD_LATENCY  clk cycles (>=1) from rd_clock fall to valid rd_data
//
//   Ports
//     clk, reset  clock; asynchronous active-high reset
//     start       1-cycle request; samples addr and len
//     addr        address of first byte
//     len         byte count: 2'b00 = 4, otherwise 1..3
//     word        assembled word, updated only when done rises
//     done        completion flag, held until next start
//     busy        high while a read sequence is in progress
//     rd_addr     buffer read address (wraps as a plain AW-bit counter)
//     rd_clock    one 1-cycle strobe per byte; the RAM latches rd_addr on rise
//     rd_en       read enable, high for the whole sequence
//     rd_data     buffer read data
//
//   Build option
//     READ_BYTES_BSWAP_EN  when defined, the first byte lands in word[31:24]
//                          (big-endian). When undefined, the first byte lands
//                          in word[7:0]. Timing is the same either way.
// -----------------------------------------------------------------------------
module read_bytes #(
  parameter int NUMBER     = 256,
  parameter int RD_LATENCY = 1,
  localparam int AW        = (NUMBER > 1) ? $clog2(NUMBER) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [AW-1:0] addr,
  input  logic [1:0]    len,
  output logic [31:0]   word,
  output logic          done,
  output logic          busy,
  output logic [AW-1:0] rd_addr,
  output logic          rd_clock,
  output logic          rd_en,
  input  logic [7:0]    rd_data
);

  localparam int LW = $clog2(RD_LATENCY + 1);

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    STRB,
    WAIT
  } state_t;

  state_t        state, state_n;
  logic [1:0]    idx, idx_n;     // index of the byte currently being read
  logic [1:0]    last, last_n;   // index of the final byte (byte count - 1)
  logic [LW-1:0] lat, lat_n;     // read latency countdown
  logic [31:0]   lanes, lanes_n; // bytes collected so far

  logic [31:0]   word_n;
  logic          done_n, busy_n, rd_clock_n, rd_en_n;
  logic [AW-1:0] rd_addr_n;

  logic [1:0]    lane_sel;
  logic [31:0]   lane_data;
  logic [31:0]   sampled;

  // Pick the word lane for byte idx. The big-endian lane is 3-idx, which is
  // the same as ~idx on two bits.
`ifdef READ_BYTES_BSWAP_EN
  assign lane_sel = ~idx;
`else
  assign lane_sel = idx;
`endif

  assign lane_data = 32'(rd_data) << {lane_sel, 3'b000};
  assign sampled   = lanes | lane_data;

  // Next-state and output logic. A start always wins, even over the
  // final-byte sample in the same cycle. A sequence that was running is then
  // dropped, and word is left unchanged.
  always_comb begin
    state_n    = state;
    idx_n      = idx;
    last_n     = last;
    lat_n      = lat;
    lanes_n    = lanes;
    word_n     = word;
    done_n     = done;
    busy_n     = busy;
    rd_addr_n  = rd_addr;
    rd_clock_n = rd_clock;
    rd_en_n    = rd_en;

    if (start) begin
      rd_addr_n  = addr;
      rd_en_n    = 1'b1;
      busy_n     = 1'b1;
      done_n     = 1'b0;
      rd_clock_n = 1'b0;
      // len-1 on two bits maps 2'b00 to 3, which is a 4-byte read.
      last_n     = len - 2'd1;
      idx_n      = '0;
      lanes_n    = '0;
      lat_n      = '0;
      state_n    = ADDR;
    end else begin
      unique case (state)
        IDLE: ;
        ADDR: begin
          rd_clock_n = 1'b1;
          state_n    = STRB;
        end
        STRB: begin
          rd_clock_n = 1'b0;
          lat_n      = LW'(RD_LATENCY);
          state_n    = WAIT;
        end
        WAIT: begin
          lat_n = lat - LW'(1);
          if (lat == LW'(1)) begin
            // The counter reaches zero on this edge, so rd_data is valid now.
            if (idx == last) begin
              word_n  = sampled;
              lanes_n = '0;
              done_n  = 1'b1;
              busy_n  = 1'b0;
              rd_en_n = 1'b0;
              state_n = IDLE;
            end else begin
              lanes_n   = sampled;
              idx_n     = idx + 2'd1;
              rd_addr_n = rd_addr + AW'(1);
              state_n   = ADDR;
            end
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      idx      <= '0;
      last     <= '0;
      lat      <= '0;
      lanes    <= '0;
      word     <= '0;
      done     <= 1'b0;
      busy     <= 1'b0;
      rd_addr  <= '0;
      rd_clock <= 1'b0;
      rd_en    <= 1'b0;
    end else begin
      state    <= state_n;
      idx      <= idx_n;
      last     <= last_n;
      lat      <= lat_n;
      lanes    <= lanes_n;
      word     <= word_n;
      done     <= done_n;
      busy     <= busy_n;
      rd_addr  <= rd_addr_n;
      rd_clock <= rd_clock_n;
      rd_en    <= rd_en_n;
    end
  end

endmodule

// File: tb/tb_read_bytes.sv
// -----------------------------------------------------------------------------
// tb_read_bytes
//   Self-checking bench for read_bytes. A byte-wide memory responder drives
//   rd_data. A timeline model predicts every output from three values: the
//   number of clock edges since the last accepted start, the byte count, and
//   the start address.
// -----------------------------------------------------------------------------
module tb_read_bytes;

  localparam int NUMBER = 256;
  localparam int RDL    = 1;
  localparam int AW     = 8;
  localparam int P      = 2 + RDL;   // clk cycles per byte

`ifdef READ_BYTES_BSWAP_EN
  localparam logic [31:0] W1 = 32'h11223344;
  localparam logic [31:0] W2 = 32'hAABB0000;
  localparam logic [31:0] W3 = 32'h5A6B7C8D;
  localparam logic [31:0] W4 = 32'h01020304;
  localparam logic [31:0] W5 = 32'h11000000;
`else
  localparam logic [31:0] W1 = 32'h44332211;
  localparam logic [31:0] W2 = 32'h0000BBAA;
  localparam logic [31:0] W3 = 32'h8D7C6B5A;
  localparam logic [31:0] W4 = 32'h04030201;
  localparam logic [31:0] W5 = 32'h00000011;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] addr = '0;
  logic [1:0]    len = '0;
  logic [31:0]   word;
  logic          done, busy;
  logic [AW-1:0] rd_addr;
  logic          rd_clock, rd_en;
  logic [7:0]    rd_data = '0;

  read_bytes #(.NUMBER(NUMBER), .RD_LATENCY(RDL)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .addr     (addr),
    .len      (len),
    .word     (word),
    .done     (done),
    .busy     (busy),
    .rd_addr  (rd_addr),
    .rd_clock (rd_clock),
    .rd_en    (rd_en),
    .rd_data  (rd_data)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- memory responder ----------------
  // The memory latches rd_addr on the rising edge of rd_clock. It shows junk
  // on rd_data until RDL cycles after the strobe falls, then the stored byte.
  logic [7:0] mem [NUMBER];
  logic       prev_rc = 1'b0;
  int         mcnt = 0;
  logic [7:0] mlat = '0;

  always @(negedge clk) begin
    if (mcnt > 0) begin
      mcnt--;
      if (mcnt == 0) rd_data = mlat;
    end
    if (rd_clock && !prev_rc) begin
      mlat    = mem[rd_addr];
      mcnt    = RDL;
      rd_data = 8'($urandom);
    end
    prev_rc = rd_clock;
  end

  // ---------------- timeline reference model ----------------
  longint        cyc = 0;
  longint        t0 = 0;
  bit            active = 1'b0;
  logic [AW-1:0] m_addr = '0;
  int            m_n = 1;
  logic [31:0]   m_exp = '0;
  logic [31:0]   m_prev = '0;

  function automatic logic [31:0] assemble(input logic [AW-1:0] a, input int n);
    logic [31:0]   w;
    logic [AW-1:0] ak;
    w = '0;
    for (int k = 0; k < n; k++) begin
      ak = a + AW'(k);
`ifdef READ_BYTES_BSWAP_EN
      w[8*(3-k) +: 8] = mem[ak];
`else
      w[8*k +: 8] = mem[ak];
`endif
    end
    return w;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      active = 1'b0;
      m_prev = '0;
      m_addr = '0;
      m_n    = 1;
    end else begin
      cyc++;
      if (start) begin
        // The previous word is kept only if its completion edge already passed.
        if (active && cyc > t0 + longint'(m_n * P)) m_prev = m_exp;
        active = 1'b1;
        t0     = cyc;
        m_addr = addr;
        m_n    = (len == 2'd0) ? 4 : int'(len);
        m_exp  = assemble(addr, m_n);
      end
    end
  end

  always @(negedge clk) begin
    logic          eb, ed, erc;
    logic [AW-1:0] ea;
    logic [31:0]   ew;
    longint        t, d;
    if (active) begin
      t   = cyc - t0;
      d   = longint'(m_n * P);
      eb  = (t < d);
      ed  = (t >= d);
      erc = (t < d) && (t % P == 1);
      ea  = m_addr + AW'((t < d) ? t / P : longint'(m_n - 1));
      ew  = (t >= d) ? m_exp : m_prev;
    end else begin
      eb  = 1'b0;
      ed  = 1'b0;
      erc = 1'b0;
      ea  = '0;
      ew  = m_prev;
    end
    chk("busy",     32'(busy),     32'(eb));
    chk("done",     32'(done),     32'(ed));
    chk("rd_en",    32'(rd_en),    32'(eb));
    chk("rd_clock", 32'(rd_clock), 32'(erc));
    chk("rd_addr",  32'(rd_addr),  32'(ea));
    chk("word",     word,          ew);
  end

  // ---------------- stimulus helpers ----------------
  // Call at a negedge. Start is sampled on the following posedge (T0). The
  // task returns at the negedge right after T0.
  task automatic do_start(input logic [AW-1:0] a, input logic [1:0] l);
    start = 1'b1;
    addr  = a;
    len   = l;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(output int cycles, output int strobes);
    cycles  = 0;
    strobes = 0;
    while (!done && cycles < 4 * P + 8) begin
      @(negedge clk);
      cycles++;
      if (rd_clock) strobes++;
    end
    if (!done) begin
      failures++;
      checks++;
      $display("FAIL done_timeout actual=%0d cycles required<=%0d", cycles, 4 * P);
    end
  endtask

  task automatic pulse_reset();
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("rst_word",     word,              32'h0);
    chk("rst_done",     32'(done),         32'h0);
    chk("rst_busy",     32'(busy),         32'h0);
    chk("rst_rd_addr",  32'(rd_addr),      32'h0);
    chk("rst_rd_clock", 32'(rd_clock),     32'h0);
    chk("rst_rd_en",    32'(rd_en),        32'h0);
    @(negedge clk);
    #2 reset = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    int cy, st, n;
    for (int i = 0; i < NUMBER; i++) mem[i] = 8'($urandom);
    mem[8'h10] = 8'h11; mem[8'h11] = 8'h22; mem[8'h12] = 8'h33; mem[8'h13] = 8'h44;
    mem[8'h20] = 8'hAA; mem[8'h21] = 8'hBB;
    mem[8'hFE] = 8'h5A; mem[8'hFF] = 8'h6B; mem[8'h00] = 8'h7C; mem[8'h01] = 8'h8D;
    mem[8'h40] = 8'h01; mem[8'h41] = 8'h02; mem[8'h42] = 8'h03; mem[8'h43] = 8'h04;

    #1 reset = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset_word", word, 32'h0);
    chk("reset_done", 32'(done), 32'h0);
    #2 reset = 1'b0;
    @(negedge clk);

    // Four-byte read.
    do_start(8'h10, 2'd0);
    wait_done(cy, st);
    chk("c1_word", word, W1);
    chk("c1_latency", 32'(cy), 32'd12);
    chk("c1_strobes", 32'(st), 32'd4);

    // Two-byte read.
    do_start(8'h20, 2'd2);
    wait_done(cy, st);
    chk("c2_word", word, W2);
    chk("c2_latency", 32'(cy), 32'd6);
    chk("c2_strobes", 32'(st), 32'd2);
    @(negedge clk);
    chk("c2_rd_en_low", 32'(rd_en), 32'h0);

    // Address wrap FE, FF, 00, 01.
    do_start(8'hFE, 2'd0);
    wait_done(cy, st);
    chk("c3_word", word, W3);

    // Restart at T0+4.
    do_start(8'h10, 2'd0);
    repeat (3) @(negedge clk);
    do_start(8'h40, 2'd0);
    wait_done(cy, st);
    chk("c4_word", word, W4);
    chk("c4_latency", 32'(cy), 32'd12);
    chk("c4_strobes", 32'(st), 32'd4);

    // Single byte.
    do_start(8'h10, 2'd1);
    wait_done(cy, st);
    chk("c5_word", word, W5);

    // Start in the same cycle as the final sample: the start wins.
    do_start(8'h20, 2'd1);
    repeat (2) @(negedge clk);
    do_start(8'h10, 2'd0);
    chk("c6_word_kept", word, W5);
    chk("c6_done_low", 32'(done), 32'h0);
    wait_done(cy, st);
    chk("c6_word", word, W1);

    // Reset mid-sequence, then a clean read.
    do_start(8'h40, 2'd0);
    repeat (6) @(negedge clk);
    pulse_reset();
    do_start(8'h10, 2'd0);
    wait_done(cy, st);
    chk("c7_word", word, W1);
    chk("c7_latency", 32'(cy), 32'd12);

    // Randomized traffic, with aborts, idle gaps, memory updates and resets.
    for (int i = 0; i < 300; i++) begin
      n = $urandom_range(0, 3);
      do_start(AW'($urandom), 2'(n));
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(0, 4 * P)) @(negedge clk);
        do_start(AW'($urandom), 2'($urandom_range(0, 3)));
      end
      if (!done) wait_done(cy, st);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      for (int k = 0; k < 4; k++) mem[$urandom_range(0, NUMBER - 1)] = 8'($urandom);
      if ($urandom_range(0, 29) == 0) pulse_reset();
    end

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
